// File: rtl/lm32_compare_stage_pkg.sv
// Shared definitions for the LM32 compare stage: condition codes and
// datapath ranges used by the compare stage and the condition evaluator.
package lm32_compare_stage_pkg;

  localparam int LM32_WORD_WIDTH = 32;
  localparam int LM32_PC_WIDTH   = 30;

  localparam logic LM32_TRUE  = 1'b1;
  localparam logic LM32_FALSE = 1'b0;

  typedef enum logic [2:0] {
    LM32_CONDITION_U1  = 3'b000,
    LM32_CONDITION_E   = 3'b001,
    LM32_CONDITION_G   = 3'b010,
    LM32_CONDITION_GE  = 3'b011,
    LM32_CONDITION_GEU = 3'b100,
    LM32_CONDITION_GU  = 3'b101,
    LM32_CONDITION_U2  = 3'b110,
    LM32_CONDITION_NE  = 3'b111
  } lm32_condition_e;

endpackage

// File: rtl/lm32_condition_eval.sv
// Purely combinational condition evaluator: maps the subtraction flags and
// a 3-bit condition code onto a single condition-met bit. Also used by the
// D-stage branch predictor.
module lm32_condition_eval
  import lm32_compare_stage_pkg::*;
(
  input  logic       zero_i,
  input  logic       ge_s_i,
  input  logic       ge_u_i,
  input  logic [2:0] condition_i,
  output logic       condition_met_o
);

  // Decode the condition code against the flags
  always_comb begin
    condition_met_o = LM32_TRUE;
    case (lm32_condition_e'(condition_i))
      LM32_CONDITION_U1:  condition_met_o = LM32_TRUE;
      LM32_CONDITION_U2:  condition_met_o = LM32_TRUE;
      LM32_CONDITION_E:   condition_met_o = zero_i;
      LM32_CONDITION_NE:  condition_met_o = ~zero_i;
      LM32_CONDITION_G:   condition_met_o = ge_s_i & ~zero_i;
      LM32_CONDITION_GE:  condition_met_o = ge_s_i;
      LM32_CONDITION_GU:  condition_met_o = ge_u_i & ~zero_i;
      LM32_CONDITION_GEU: condition_met_o = ge_u_i;
      default:            condition_met_o = LM32_TRUE;
    endcase
  end

endmodule

// File: rtl/lm32_compare_stage.sv
// LM32 X->M compare stage: evaluates the compare/branch condition from the
// X-stage subtractor flags, and registers condition, compare value and branch
// resolution into the M pipeline register with stall/kill handling.
// Optional: `define CFG_BRANCH_STATS_EN adds saturating branch/mispredict
// counters with a clear input.
module lm32_compare_stage
  import lm32_compare_stage_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int PC_WIDTH   = 30,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_x,
  input  logic [2:0]            condition_x,
  input  logic                  branch_x,
  input  logic                  predict_taken_x,
  input  logic [PC_WIDTH-1:0]   branch_target_x,
  input  logic [PC_WIDTH-1:0]   pc_x,
  input  logic [WORD_WIDTH-1:0] adder_result_x,
  input  logic                  adder_carry_n_x,
  input  logic                  adder_overflow_x,
  input  logic                  stall_m,
  input  logic                  kill_x,
  input  logic                  kill_m,
`ifdef CFG_BRANCH_STATS_EN
  input  logic                  stats_clr_i,
  output logic [STAT_WIDTH-1:0] branch_count_o,
  output logic [STAT_WIDTH-1:0] mispredict_count_o,
`endif
  output logic                  valid_m,
  output logic                  condition_met_m,
  output logic [WORD_WIDTH-1:0] compare_result_m,
  output logic                  branch_m,
  output logic                  branch_taken_m,
  output logic                  mispredict_m,
  output logic [PC_WIDTH-1:0]   redirect_pc_m
);

  logic zero_x, neg_x, ge_s_x, ge_u_x, condition_met_x;

  assign zero_x = (adder_result_x == '0);
  assign neg_x  = adder_result_x[WORD_WIDTH-1];
  // Signed >= : sign of the difference, corrected by overflow
  assign ge_s_x = ~(neg_x ^ adder_overflow_x);
  assign ge_u_x = adder_carry_n_x;

  lm32_condition_eval u_cond_eval (
    .zero_i          (zero_x),
    .ge_s_i          (ge_s_x),
    .ge_u_i          (ge_u_x),
    .condition_i     (condition_x),
    .condition_met_o (condition_met_x)
  );

  logic                valid_d, branch_d, taken_d;
  logic [PC_WIDTH-1:0] redirect_d;

  assign valid_d    = valid_x & ~kill_x;
  assign branch_d   = branch_x & valid_d;
  assign taken_d    = branch_d & condition_met_x;
  // pc+1 wraps naturally at PC_WIDTH bits
  assign redirect_d = taken_d ? branch_target_x : pc_x + PC_WIDTH'(1);

  // ---- X -> M pipeline register boundary ----
  logic                valid_q, cond_met_q, branch_q, taken_q, predicted_q;
  logic [PC_WIDTH-1:0] redirect_q;

  // M register: reset > kill > stall > load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      cond_met_q  <= 1'b0;
      branch_q    <= 1'b0;
      taken_q     <= 1'b0;
      predicted_q <= 1'b0;
      redirect_q  <= '0;
    end else if (kill_m) begin
      // taken is cleared too so a flushed entry never looks taken
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
    end else if (!stall_m) begin
      valid_q     <= valid_d;
      cond_met_q  <= condition_met_x;
      branch_q    <= branch_d;
      taken_q     <= taken_d;
      predicted_q <= predict_taken_x;
      redirect_q  <= redirect_d;
    end
  end

  assign valid_m          = valid_q;
  assign condition_met_m  = cond_met_q;
  assign compare_result_m = {{(WORD_WIDTH-1){1'b0}}, cond_met_q};
  assign branch_m         = branch_q;
  assign branch_taken_m   = taken_q;
  assign redirect_pc_m    = redirect_q;
  assign mispredict_m     = valid_q & branch_q & (taken_q != predicted_q);

`ifdef CFG_BRANCH_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

  logic                  retire_branch;
  logic [STAT_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;

  assign retire_branch = valid_q & branch_q & ~stall_m & ~kill_m;

  // Saturating statistics counters; clear beats increment
  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (retire_branch) begin
      branch_cnt_q <= sat_inc(branch_cnt_q);
      if (mispredict_m) mispredict_cnt_q <= sat_inc(mispredict_cnt_q);
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_lm32_compare_stage.sv
// Directed testbench for lm32_compare_stage with hand-computed expectations.
module tb_lm32_compare_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_x, branch_x, predict_taken_x;
  logic [2:0]  condition_x;
  logic [29:0] branch_target_x, pc_x;
  logic [31:0] adder_result_x;
  logic        adder_carry_n_x, adder_overflow_x;
  logic        stall_m, kill_x, kill_m;
  logic        valid_m, condition_met_m, branch_m, branch_taken_m, mispredict_m;
  logic [31:0] compare_result_m;
  logic [29:0] redirect_pc_m;
`ifdef CFG_BRANCH_STATS_EN
  logic        stats_clr_i;
  logic [15:0] branch_count_o, mispredict_count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  lm32_compare_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .valid_x          (valid_x),
    .condition_x      (condition_x),
    .branch_x         (branch_x),
    .predict_taken_x  (predict_taken_x),
    .branch_target_x  (branch_target_x),
    .pc_x             (pc_x),
    .adder_result_x   (adder_result_x),
    .adder_carry_n_x  (adder_carry_n_x),
    .adder_overflow_x (adder_overflow_x),
    .stall_m          (stall_m),
    .kill_x           (kill_x),
    .kill_m           (kill_m),
`ifdef CFG_BRANCH_STATS_EN
    .stats_clr_i        (stats_clr_i),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o),
`endif
    .valid_m          (valid_m),
    .condition_met_m  (condition_met_m),
    .compare_result_m (compare_result_m),
    .branch_m         (branch_m),
    .branch_taken_m   (branch_taken_m),
    .mispredict_m     (mispredict_m),
    .redirect_pc_m    (redirect_pc_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_alu(input logic [31:0] res, input logic cn, input logic ovf, input logic [2:0] cond);
    adder_result_x   = res;
    adder_carry_n_x  = cn;
    adder_overflow_x = ovf;
    condition_x      = cond;
  endtask

  initial begin
    rst_i = 1'b1; valid_x = 1'b0; branch_x = 1'b0; predict_taken_x = 1'b0;
    condition_x = 3'b000; branch_target_x = '0; pc_x = '0;
    adder_result_x = '0; adder_carry_n_x = 1'b0; adder_overflow_x = 1'b0;
    stall_m = 1'b0; kill_x = 1'b0; kill_m = 1'b0;
`ifdef CFG_BRANCH_STATS_EN
    stats_clr_i = 1'b0;
`endif
    valid_x = 1'b1; branch_x = 1'b1; condition_x = 3'b000;
    step(); step();
    chk("rst_valid", 32'(valid_m), 0);
    chk("rst_met", 32'(condition_met_m), 0);
    chk("rst_cmp", compare_result_m, 0);
    chk("rst_branch", 32'(branch_m), 0);
    chk("rst_taken", 32'(branch_taken_m), 0);
    chk("rst_mispred", 32'(mispredict_m), 0);
    chk("rst_redirect", 32'(redirect_pc_m), 0);
    rst_i = 1'b0; branch_x = 1'b0;

    // Compare evaluation
    set_alu(32'h0, 1'b1, 1'b0, 3'b001); step();
    chk("E_valid", 32'(valid_m), 1);
    chk("E_met", 32'(condition_met_m), 1);
    chk("E_cmp", compare_result_m, 32'h1);
    chk("E_branch", 32'(branch_m), 0);
    set_alu(32'h80000000, 1'b0, 1'b1, 3'b011); step();
    chk("GE_ovf", 32'(condition_met_m), 1);
    set_alu(32'h80000000, 1'b0, 1'b1, 3'b010); step();
    chk("G_ovf", 32'(condition_met_m), 1);
    set_alu(32'h80000000, 1'b0, 1'b0, 3'b011); step();
    chk("GE_neg", 32'(condition_met_m), 0);
    chk("GE_neg_cmp", compare_result_m, 0);
    set_alu(32'hFFFFFFFF, 1'b0, 1'b0, 3'b100); step();
    chk("GEU_borrow", 32'(condition_met_m), 0);
    set_alu(32'hFFFFFFFF, 1'b0, 1'b0, 3'b101); step();
    chk("GU_borrow", 32'(condition_met_m), 0);
    set_alu(32'hFFFFFFFF, 1'b0, 1'b0, 3'b111); step();
    chk("NE_nonzero", 32'(condition_met_m), 1);
    set_alu(32'hFFFFFFFF, 1'b0, 1'b0, 3'b001); step();
    chk("E_nonzero", 32'(condition_met_m), 0);
    set_alu(32'h0, 1'b1, 1'b0, 3'b010); step();
    chk("G_zero", 32'(condition_met_m), 0);
    set_alu(32'h0, 1'b1, 1'b0, 3'b101); step();
    chk("GU_zero", 32'(condition_met_m), 0);
    set_alu(32'h0, 1'b1, 1'b0, 3'b100); step();
    chk("GEU_zero", 32'(condition_met_m), 1);
    set_alu(32'h5, 1'b1, 1'b0, 3'b101); step();
    chk("GU_pos", 32'(condition_met_m), 1);
    set_alu(32'h7, 1'b0, 1'b0, 3'b110); step();
    chk("U2", 32'(condition_met_m), 1);
    set_alu(32'h7, 1'b0, 1'b0, 3'b000); step();
    chk("U1", 32'(condition_met_m), 1);

    // Branch resolution
    branch_x = 1'b1; branch_target_x = 30'h100; pc_x = 30'h40;
    set_alu(32'h0, 1'b1, 1'b0, 3'b001); predict_taken_x = 1'b0; step();
    chk("br_taken", 32'(branch_taken_m), 1);
    chk("br_branch", 32'(branch_m), 1);
    chk("br_mispred", 32'(mispredict_m), 1);
    chk("br_redirect", 32'(redirect_pc_m), 32'h100);
    predict_taken_x = 1'b1; step();
    chk("br_pred_ok", 32'(mispredict_m), 0);
    set_alu(32'h0, 1'b1, 1'b0, 3'b111); step();
    chk("nt_taken", 32'(branch_taken_m), 0);
    chk("nt_mispred", 32'(mispredict_m), 1);
    chk("nt_redirect", 32'(redirect_pc_m), 32'h41);
    pc_x = 30'h3FFFFFFF; predict_taken_x = 1'b0; step();
    chk("pc_wrap", 32'(redirect_pc_m), 0);
    chk("pc_wrap_mispred", 32'(mispredict_m), 0);

    // Stall freezes a taken, mispredicted branch while X changes
    pc_x = 30'h40; set_alu(32'h0, 1'b1, 1'b0, 3'b001); predict_taken_x = 1'b0; step();
    stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(32'h1 + 32'(i), 1'b0, 1'b0, 3'b001);
      branch_x = 1'(i & 1); valid_x = 1'(i & 1); pc_x = 30'h200 + 30'(i);
      step();
      chk("stall_valid", 32'(valid_m), 1);
      chk("stall_taken", 32'(branch_taken_m), 1);
      chk("stall_redirect", 32'(redirect_pc_m), 32'h100);
      chk("stall_met", 32'(condition_met_m), 1);
    end
    kill_m = 1'b1; step();
    chk("killm_valid", 32'(valid_m), 0);
    chk("killm_branch", 32'(branch_m), 0);
    chk("killm_taken", 32'(branch_taken_m), 0);
    chk("killm_mispred", 32'(mispredict_m), 0);
    kill_m = 1'b0; stall_m = 1'b0;

    // kill_x and invalid X
    valid_x = 1'b1; branch_x = 1'b1; kill_x = 1'b1; condition_x = 3'b000; step();
    chk("killx_valid", 32'(valid_m), 0);
    chk("killx_branch", 32'(branch_m), 0);
    chk("killx_taken", 32'(branch_taken_m), 0);
    kill_x = 1'b0; valid_x = 1'b0; step();
    chk("inv_taken", 32'(branch_taken_m), 0);
    chk("inv_mispred", 32'(mispredict_m), 0);

    // Reset during a stall discards the entry
    valid_x = 1'b1; step();
    chk("pre_rst_valid", 32'(valid_m), 1);
    stall_m = 1'b1; rst_i = 1'b1; step();
    chk("rst_stall_valid", 32'(valid_m), 0);
    chk("rst_stall_branch", 32'(branch_m), 0);
    rst_i = 1'b0; stall_m = 1'b0;

`ifdef CFG_BRANCH_STATS_EN
    valid_x = 1'b0; branch_x = 1'b0; step(); step();
    stats_clr_i = 1'b1; step(); stats_clr_i = 1'b0;
    chk("stats_clr0", 32'(branch_count_o), 0);
    valid_x = 1'b1; branch_x = 1'b1; condition_x = 3'b000; predict_taken_x = 1'b0;
    for (int i = 0; i < 5; i++) step();
    valid_x = 1'b0; step(); step();
    chk("stats_br5", 32'(branch_count_o), 5);
    chk("stats_mp5", 32'(mispredict_count_o), 5);
    valid_x = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    valid_x = 1'b0; step(); step();
    chk("stats_br_sat", 32'(branch_count_o), 32'hFFFF);
    chk("stats_mp_sat", 32'(mispredict_count_o), 32'hFFFF);
    stats_clr_i = 1'b1; step(); stats_clr_i = 1'b0;
    chk("stats_br_clr", 32'(branch_count_o), 0);
    chk("stats_mp_clr", 32'(mispredict_count_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
